// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter among NUM_REQ byte sources, with a hang watchdog.
// Defining UART_TX_SCHED_LOCK_EN keeps a source granted until the byte flagged I_LAST.
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 20000,
  parameter int CNT_W   = 16,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                 I_CLK,
  input  logic                 I_RESET_N,
  input  logic [NUM_REQ-1:0]   I_REQ,
  input  logic [8*NUM_REQ-1:0] I_DATA,
  input  logic [NUM_REQ-1:0]   I_LAST,
  output logic [NUM_REQ-1:0]   O_ACK,
  input  logic                 I_TX_READY,
  input  logic                 I_TX_DONE,
  output logic                 O_TX_START,
  output logic [7:0]           O_TX_DATA,
  output logic [IW-1:0]        O_GRANT_ID,
  output logic                 O_BUSY,
  output logic                 O_TIMEOUT,
  output logic [CNT_W-1:0]     O_TX_COUNT
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCEPT, LAUNCH, WAIT} state_t;
  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d, grant_q, grant_d, win;
  logic [7:0]           data_q, data_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d, req_eff;
  logic                 start_q, start_d, busy_q, busy_d, to_q, to_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic                 go, expire;
`ifdef UART_TX_SCHED_LOCK_EN
  logic lock_q, lock_d;
  assign req_eff = (lock_q && I_REQ[grant_q]) ? NUM_REQ'(1) << grant_q : I_REQ;
  always_comb
    lock_d = (state_q == IDLE && go) ? !I_LAST[win] :
             ((state_q == IDLE && !I_REQ[grant_q]) || (state_q == WAIT && !I_TX_DONE && expire)) ? 1'b0 : lock_q;
  always_ff @(posedge I_CLK or negedge I_RESET_N)
    if (!I_RESET_N) lock_q <= 1'b0;
    else lock_q <= lock_d;
`else
  logic unused_last;
  assign unused_last = ^I_LAST;
  assign req_eff = I_REQ;
`endif
  assign go     = I_TX_READY && |req_eff;
  assign expire = wd_q == WW'(TIMEOUT - 2);
  // search ptr+1, ptr+2, ... ; descending loop so the nearest source wins
  always_comb begin
    win = ptr_q;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req_eff[IW'((int'(ptr_q) + i) % NUM_REQ)]) win = IW'((int'(ptr_q) + i) % NUM_REQ);
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    ack_d   = '0;
    start_d = 1'b0;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: if (go) begin
        grant_d = win;
        data_d  = I_DATA[8*win +: 8];
        ack_d   = NUM_REQ'(1) << win;
        state_d = ACCEPT;
      end
      ACCEPT: begin
        start_d = 1'b1;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      default: begin
        wd_d = wd_q + WW'(1);
        if (I_TX_DONE || expire) begin
          cnt_d   = I_TX_DONE ? cnt_q + CNT_W'(1) : cnt_q;
          to_d    = !I_TX_DONE;
          ptr_d   = grant_q;
          state_d = IDLE;
        end
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge I_CLK or negedge I_RESET_N)
    if (!I_RESET_N) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  assign O_ACK      = ack_q;
  assign O_TX_START = start_q;
  assign O_TX_DATA  = data_q;
  assign O_GRANT_ID = grant_q;
  assign O_BUSY     = busy_q;
  assign O_TIMEOUT  = to_q;
  assign O_TX_COUNT = cnt_q;
endmodule
